// File: rtl/sw_input_ctrl.sv
// Avalon-MM slave for board switches/buttons: synchronise, debounce, capture
// edges with selectable polarity, and raise a maskable level interrupt.
module sw_input_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [WIDTH-1:0] sw_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [1:0]       mode;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_stable[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise = sw_stable & ~prev;
    fall = ~sw_stable & prev;
    if (mode[1])      qual = rise | fall;
    else if (mode[0]) qual = fall;
    else              qual = rise;
    clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  end

  // A new edge overrides a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      mode        <= '0;
    end else begin
      prev        <= sw_stable;
      edgecapture <= (edgecapture & ~clr) | qual;
      if (wr_en && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
      if (wr_en && address == 2'd3) mode    <= writedata[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(sw_stable);
        2'd1:    readdata <= 32'(irqmask);
        2'd2:    readdata <= 32'(edgecapture);
        default: readdata <= 32'(mode);
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
